// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device: inhibits the clock, issues the
// start bit, shifts D0..D7, odd parity and stop on device clock falls, then
// checks the device ACK. Every wait on the device is guarded by a timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC  = 5600,
    parameter int unsigned START_TO_CYC = 840000,
    parameter int unsigned BIT_TO_CYC   = 112000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYC - 1);
    localparam logic [19:0] START_LIMIT  = 20'(START_TO_CYC);
    localparam logic [19:0] BIT_LIMIT    = 20'(BIT_TO_CYC);
    localparam logic [3:0]  STOP_IDX     = 4'd9;

    state_t      state;
    state_t      state_next;
    logic        clk_meta;
    logic        clk_sync;
    logic        data_meta;
    logic        data_sync;
    logic [3:0]  clk_hist;
    logic        fall;
    logic [19:0] cnt;
    logic        cnt_clear;
    logic [3:0]  bit_idx;
    logic [3:0]  bit_idx_next;
    logic [7:0]  tx_byte;
    logic        tx_parity;
    logic        tx_bit;
    logic        accept;
    logic        abort;
    logic        done;

    // A fall is one old high sample followed by three consecutive low samples.
    assign fall   = (clk_hist == 4'b1000);
    assign accept = tx_valid && tx_ready;

    // Bring the raw PS/2 lines into clk_sys and keep a short clock history.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_hist  <= 4'b1111;
        end else begin
            clk_meta  <= ps2_kbd_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_kbd_data;
            data_sync <= data_meta;
            clk_hist  <= {clk_hist[2:0], clk_sync};
        end
    end

    // Select the frame bit for the current index: data, parity, then stop.
    always_comb begin
        tx_bit = 1'b1;
        if (bit_idx < 4'd8) begin
            tx_bit = tx_byte[bit_idx[2:0]];
        end else if (bit_idx == 4'd8) begin
            tx_bit = tx_parity;
        end
    end

    // Next-state, abort/done decisions and line drive for the transfer.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        cnt_clear    = 1'b0;
        abort        = 1'b0;
        done         = 1'b0;
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;

        case (state)
            ST_IDLE: begin
                bit_idx_next = 4'd0;
                if (accept) begin
                    state_next = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt >= INHIBIT_LAST) begin
                    ps2_data_oe = 1'b1;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                ps2_data_oe = 1'b1;
                if (fall) begin
                    state_next   = ST_SEND;
                    bit_idx_next = 4'd0;
                end else if (cnt >= START_LIMIT) begin
                    abort = 1'b1;
                end
            end
            ST_SEND: begin
                ps2_data_oe = ~tx_bit;
                if (fall) begin
                    cnt_clear = 1'b1;
                    if (bit_idx == STOP_IDX) begin
                        state_next = ST_ACK;
                    end else begin
                        bit_idx_next = 4'(bit_idx + 4'd1);
                    end
                end else if (cnt >= BIT_LIMIT) begin
                    abort = 1'b1;
                end
            end
            ST_ACK: begin
                if (fall) begin
                    cnt_clear = 1'b1;
                    if (!data_sync) begin
                        state_next = ST_WAIT_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (cnt >= BIT_LIMIT) begin
                    abort = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end else if (fall) begin
                    cnt_clear = 1'b1;
                end else if (cnt >= BIT_LIMIT) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // An abort releases both lines in the very cycle it is decided.
        if (abort) begin
            state_next  = ST_IDLE;
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
        end

        if (state_next != state) begin
            cnt_clear = 1'b1;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign tx_done  = done;
    assign tx_error = abort;

    // State register; tx_ready tracks IDLE but stays low throughout reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            tx_ready <= 1'b0;
            bit_idx  <= 4'd0;
        end else begin
            state    <= state_next;
            tx_ready <= (state_next == ST_IDLE);
            bit_idx  <= bit_idx_next;
        end
    end

    // Shared saturating timer for inhibit hold, start wait and bit timeouts.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 20'd0;
        end else if (cnt_clear) begin
            cnt <= 20'd0;
        end else if (cnt != 20'hFFFFF) begin
            cnt <= cnt + 20'd1;
        end
    end

    // Latch the byte and its odd parity on acceptance; drop it on abort.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tx_byte   <= 8'd0;
            tx_parity <= 1'b0;
        end else if (accept) begin
            tx_byte   <= tx_data;
            tx_parity <= ~^tx_data;
        end else if (abort) begin
            tx_byte   <= 8'd0;
            tx_parity <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a simple open-collector PS/2
// device model and a frame-level reference model of the expected result.
module tb_ps2_host_tx;

    localparam int INH      = 40;
    localparam int START_TO = 300;
    localparam int BIT_TO   = 200;
    localparam int LOW      = 15;
    localparam int HIGH     = 15;
    // Line fall to cleared timer: two sync flops, three filter samples, one register.
    localparam int SYNC_LAT = 6;

    localparam int MODE_ACK     = 0;
    localparam int MODE_NACK    = 1;
    localparam int MODE_NOCLK   = 2;
    localparam int MODE_STALL4  = 3;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    int n_compared = 0;
    int n_mismatch = 0;
    int done_pulses = 0;
    int err_pulses  = 0;
    int overlap     = 0;

    // Open-collector bus: either side pulling low wins.
    assign ps2_kbd_clk  = ~(dev_clk_low | ps2_clk_oe);
    assign ps2_kbd_data = ~(dev_data_low | ps2_data_oe);

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .START_TO_CYC(START_TO),
        .BIT_TO_CYC  (BIT_TO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_kbd_clk (ps2_kbd_clk),
        .ps2_kbd_data(ps2_kbd_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    // System clock.
    always #5 clk_sys = ~clk_sys;

    // Tally completion pulses away from the active edge.
    always @(negedge clk_sys) begin
        if (tx_done === 1'b1) done_pulses++;
        if (tx_error === 1'b1) err_pulses++;
        if (tx_done === 1'b1 && tx_error === 1'b1) overlap++;
    end

    // Runaway guard.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame as seen on the data line: D0..D7, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // One device clock pulse; data is sampled at the end of the low phase.
    task automatic dev_pulse(output logic sample);
        dev_clk_low = 1'b1;
        repeat (LOW - 1) @(negedge clk_sys);
        sample = ps2_kbd_data;
        @(negedge clk_sys);
        dev_clk_low = 1'b0;
        repeat (HIGH) @(negedge clk_sys);
    endtask

    // Hand a byte over and follow the inhibit phase into START cycle 0.
    task automatic start_phase(input logic [7:0] data);
        int   inh = 0;
        logic early = 1'b0;
        logic lastd = 1'b0;
        @(negedge clk_sys);
        tx_data  = data;
        tx_valid = 1'b1;
        checkOutput("ready_before", 32'(tx_ready), 32'd1);
        @(negedge clk_sys);
        tx_valid = 1'b0;
        checkOutput("busy_inhibit", 32'(busy), 32'd1);
        checkOutput("ready_inhibit", 32'(tx_ready), 32'd0);
        while (ps2_clk_oe === 1'b1 && inh < 4 * INH) begin
            inh++;
            if (lastd) early = 1'b1;
            lastd    = ps2_data_oe;
            tx_valid = (inh == 5);
            tx_data  = (inh == 5) ? ~data : data;
            @(negedge clk_sys);
        end
        tx_valid = 1'b0;
        checkOutput("inhibit_len", 32'(inh), 32'(INH));
        checkOutput("start_bit_last_inh", 32'(lastd), 32'd1);
        checkOutput("data_oe_early", 32'(early), 32'd0);
        checkOutput("start_bit", 32'(ps2_data_oe), 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int mode);
        logic [9:0] got = 10'd0;
        logic [9:0] exp_frame;
        logic       s;
        int         done0;
        int         err0;
        int         k;
        exp_frame = model_frame(data);
        done0 = done_pulses;
        err0  = err_pulses;
        start_phase(data);
        if (mode == MODE_NOCLK) begin
            k = 0;
            while (tx_error !== 1'b1 && k < START_TO + 50) begin
                @(negedge clk_sys);
                k++;
            end
            checkOutput("start_to_delay", 32'(k), 32'(START_TO));
            checkOutput("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
            checkOutput("abort_data_oe", 32'(ps2_data_oe), 32'd0);
        end else begin
            repeat ($urandom_range(8, 20)) @(negedge clk_sys);
            if (mode == MODE_STALL4) begin
                for (int i = 0; i < 3; i++) begin
                    dev_pulse(s);
                    got[i] = s;
                end
                dev_clk_low = 1'b1;
                k = 0;
                while (tx_error !== 1'b1 && k < BIT_TO + 100) begin
                    @(negedge clk_sys);
                    k++;
                    if (k == LOW - 1) got[3] = ps2_kbd_data;
                    if (k == LOW) dev_clk_low = 1'b0;
                end
                checkOutput("bit_to_delay", 32'(k), 32'(BIT_TO + SYNC_LAT));
                checkOutput("bits_before_stall", 32'(got[3:0]), 32'(exp_frame[3:0]));
                checkOutput("abort_data_oe", 32'(ps2_data_oe), 32'd0);
            end else begin
                for (int i = 0; i < 10; i++) begin
                    dev_pulse(s);
                    got[i] = s;
                end
                dev_pulse(s);
                dev_data_low = (mode == MODE_ACK);
                @(negedge clk_sys);
                dev_clk_low = 1'b1;
                repeat (LOW) @(negedge clk_sys);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                checkOutput("frame", 32'(got), 32'(exp_frame));
            end
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (40) @(negedge clk_sys);
        checkOutput("done_pulses", 32'(done_pulses - done0), (mode == MODE_ACK) ? 32'd1 : 32'd0);
        checkOutput("err_pulses", 32'(err_pulses - err0), (mode == MODE_ACK) ? 32'd0 : 32'd1);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("ready_after", 32'(tx_ready), 32'd1);
        checkOutput("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    endtask

    // Abort a transfer by reset while bit 5 is on the line.
    task automatic reset_mid_send();
        logic s;
        int   done0;
        int   err0;
        start_phase(8'hD5);
        repeat ($urandom_range(8, 20)) @(negedge clk_sys);
        for (int i = 0; i < 5; i++) dev_pulse(s);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk_sys);
        checkOutput("bit5_driven", 32'(ps2_data_oe), 32'd1);
        done0 = done_pulses;
        err0  = err_pulses;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        checkOutput("rst_async_busy", 32'(busy), 32'd0);
        checkOutput("rst_async_flags", 32'({tx_done, tx_error, tx_ready}), 32'd0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk_sys);
        checkOutput("rst_held_ready", 32'(tx_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        checkOutput("rst_release_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_no_pulses", 32'((done_pulses - done0) + (err_pulses - err0)), 32'd0);
        repeat (5) @(negedge clk_sys);
    endtask

    initial begin
        $display("[TB] ps2_host_tx bench start");
        @(negedge clk_sys);
        checkOutput("reset_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        checkOutput("reset_flags", 32'({busy, tx_done, tx_error, tx_ready}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        checkOutput("ready_after_reset", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge clk_sys);

        applyStimulus(8'hF4, MODE_ACK);
        applyStimulus(8'hED, MODE_ACK);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), MODE_ACK);
        end
        applyStimulus(8'($urandom_range(0, 255)), MODE_NACK);
        applyStimulus(8'($urandom_range(0, 255)), MODE_NOCLK);
        applyStimulus(8'($urandom_range(0, 255)), MODE_STALL4);
        reset_mid_send();
        applyStimulus(8'hFF, MODE_ACK);
        applyStimulus(8'($urandom_range(0, 255)), MODE_ACK);

        checkOutput("done_error_overlap", 32'(overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
